interrupt_controller: RTL and testbench

- Pending-interrupt tracker for the 12-bit processor core.
- Captures asynchronous, possibly sub-cycle-wide hardware IRQ pulses and accepts software-created interrupts.
- Continuously reports the highest-priority pending interrupt number.
- The core enters interrupt mode whenever the reported value is below 12'o7777. In that mode a register read returns the number and a register write dismisses it.

---
 rtl/interrupt_controller_pkg.sv | 13 +
 rtl/irq_edge_sync.sv | 44 ++++
 rtl/interrupt_controller.sv | 69 ++++++
 tb/tb_interrupt_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared constants for the interrupt controller and the core that reads it.
package interrupt_controller_pkg;

    // Machine word width of the 12-bit core.
    localparam int unsigned WORD_W = 12;

    // Reported when nothing is pending; any smaller value puts the core in interrupt mode.
    localparam logic [WORD_W-1:0] NO_INTERRUPT = 12'o7777;

    // Register number through which the core reads and dismisses interrupts.
    localparam logic [4:0] INT_REG_NUM = 5'b10000;

endpackage

// File: rtl/irq_edge_sync.sv
// One interrupt line: edge-clocked toggle, 2-flop synchronizer into clk and change
// detector. Produces a single-cycle irq_event for every captured edge.
module irq_edge_sync
    import interrupt_controller_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic irq_event
);

    logic toggle_q;
    logic sync1_q;
    logic sync2_q;
    logic seen_q;

    // Toggle on every rising irq edge; a pulse shorter than a clk period is still recorded.
    always_ff @(posedge irq or negedge rst) begin
        if (!rst) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= ~toggle_q;
        end
    end

    // Bring the toggle into clk and keep one extra stage to spot a change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            sync1_q <= toggle_q;
            sync2_q <= sync1_q;
            seen_q  <= sync2_q;
        end
    end

    // A change in the synchronized toggle is one new request.
    always_comb begin
        irq_event = sync2_q ^ seen_q;
    end

endmodule

// File: rtl/interrupt_controller.sv
// Pending-interrupt tracker: captures hardware IRQ edges, accepts software create and
// dismiss strobes, and reports the lowest-numbered pending line.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned INTERRUPT_LINES = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INTERRUPT_LINES-1:0] irq,
    input  logic                       dismiss,
    input  logic                       create,
    input  logic [WORD_W-1:0]          data_in,
    output logic [WORD_W-1:0]          next_interrupt
);

    logic [INTERRUPT_LINES-1:0] irq_event;
    logic [INTERRUPT_LINES-1:0] set_lines;
    logic [INTERRUPT_LINES-1:0] clear_lines;
    logic [INTERRUPT_LINES-1:0] pending_d;
    logic [INTERRUPT_LINES-1:0] pending_q;

    for (genvar g = 0; g < INTERRUPT_LINES; g++) begin : g_line
        irq_edge_sync u_sync (
            .clk       (clk),
            .rst       (rst),
            .irq       (irq[g]),
            .irq_event (irq_event[g])
        );
    end

    // Decode strobes per line; out-of-range numbers match no line and are ignored.
    always_comb begin
        set_lines   = irq_event;
        clear_lines = '0;
        for (int i = 0; i < int'(INTERRUPT_LINES); i++) begin
            if (data_in == WORD_W'(i)) begin
                if (create) begin
                    set_lines[i] = 1'b1;
                end
                if (dismiss) begin
                    clear_lines[i] = 1'b1;
                end
            end
        end
        // Set wins over clear so a request arriving at dismissal is not lost.
        pending_d = (pending_q & ~clear_lines) | set_lines;
    end

    // Pending register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Priority encode: lowest index wins, walk from the top so it overwrites last.
    always_comb begin
        next_interrupt = NO_INTERRUPT;
        for (int i = int'(INTERRUPT_LINES) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                next_interrupt = WORD_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: vector table, hand-written corner
// sequences, and randomized traffic against a line-level reference model.
module tb_interrupt_controller;

    localparam int N = 24;
    localparam logic [11:0] NONE = 12'o7777;

    logic          clk;
    logic          rst;
    logic [N-1:0]  irq;
    logic          dismiss;
    logic          create;
    logic [11:0]   data_in;
    logic [11:0]   next_interrupt;

    int checks;
    int errors;

    interrupt_controller #(.INTERRUPT_LINES(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq            (irq),
        .dismiss        (dismiss),
        .create         (create),
        .data_in        (data_in),
        .next_interrupt (next_interrupt)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    typedef struct {
        logic        create;
        logic        dismiss;
        logic [11:0] data;
        logic [11:0] expect_next;
    } vec_t;

    // Reference model: one pending flag and one arrival countdown per line.
    bit model_pend [N];
    int model_delay [N];

    function automatic logic [11:0] model_next();
        for (int i = 0; i < N; i++) begin
            if (model_pend[i]) return 12'(i);
        end
        return NONE;
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %o, expected %o", name, got, want);
        end
    endtask

    // Short pulse well between clk edges.
    task automatic pulse(input logic [N-1:0] mask);
        #5;
        irq = mask;
        #2;
        irq = '0;
    endtask

    task automatic strobe(input logic c, input logic d, input logic [11:0] num);
        @(negedge clk);
        create  = c;
        dismiss = d;
        data_in = num;
        @(posedge clk);
        #1;
        create  = 1'b0;
        dismiss = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    vec_t vecs [12];

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        irq     = '0;
        dismiss = 1'b0;
        create  = 1'b0;
        data_in = '0;

        // Reset: edges during reset are discarded.
        #10;
        check("reset_value", next_interrupt, NONE);
        @(negedge clk);
        pulse(N'(1) << 3);
        @(negedge clk);
        check("reset_irq3_ignored", next_interrupt, NONE);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("after_reset_release", next_interrupt, NONE);

        // 2 ns pulse on irq[2] must appear within 3 edges and hold.
        @(negedge clk);
        pulse(N'(1) << 2);
        begin
            int k;
            k = 0;
            while (next_interrupt !== 12'd2 && k < 3) begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        check("irq2_latency", next_interrupt, 12'd2);
        repeat (3) @(posedge clk);
        #1;
        check("irq2_holds", next_interrupt, 12'd2);
        strobe(1'b0, 1'b1, 12'd2);
        check("irq2_dismissed", next_interrupt, NONE);

        // Simultaneous pulses on 1, 2, 3 then dismiss in order.
        @(negedge clk);
        pulse((N'(1) << 1) | (N'(1) << 2) | (N'(1) << 3));
        repeat (3) @(posedge clk);
        #1;
        check("multi_first", next_interrupt, 12'd1);
        strobe(1'b0, 1'b1, 12'd1);
        check("multi_after_d1", next_interrupt, 12'd2);
        strobe(1'b0, 1'b1, 12'd2);
        check("multi_after_d2", next_interrupt, 12'd3);
        strobe(1'b0, 1'b1, 12'd3);
        check("multi_after_d3", next_interrupt, NONE);

        // Vector table for software create/dismiss, starting from empty.
        vecs[0]  = '{1'b1, 1'b0, 12'd5,    12'd5};
        vecs[1]  = '{1'b1, 1'b0, 12'd30,   12'd5};
        vecs[2]  = '{1'b0, 1'b1, 12'd7,    12'd5};
        vecs[3]  = '{1'b1, 1'b0, 12'd0,    12'd0};
        vecs[4]  = '{1'b1, 1'b1, 12'd0,    12'd0};
        vecs[5]  = '{1'b0, 1'b1, 12'd0,    12'd5};
        vecs[6]  = '{1'b1, 1'b0, 12'd4095, 12'd5};
        vecs[7]  = '{1'b1, 1'b0, 12'd24,   12'd5};
        vecs[8]  = '{1'b1, 1'b0, 12'd23,   12'd5};
        vecs[9]  = '{1'b0, 1'b1, 12'd5,    12'd23};
        vecs[10] = '{1'b0, 1'b1, 12'd4095, 12'd23};
        vecs[11] = '{1'b0, 1'b1, 12'd23,   NONE};
        for (int v = 0; v < 12; v++) begin
            strobe(vecs[v].create, vecs[v].dismiss, vecs[v].data);
            check($sformatf("vec%0d", v), next_interrupt, vecs[v].expect_next);
        end

        // Dismiss line 4 in the very cycle its synchronized event lands.
        @(negedge clk);
        pulse(N'(1) << 4);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        dismiss = 1'b1;
        data_in = 12'd4;
        @(posedge clk);
        #1;
        dismiss = 1'b0;
        check("dismiss_vs_event", next_interrupt, 12'd4);
        strobe(1'b0, 1'b1, 12'd4);
        check("line4_cleared", next_interrupt, NONE);

        // Asynchronous reset mid-cycle with lines 0 and 9 pending.
        strobe(1'b1, 1'b0, 12'd9);
        strobe(1'b1, 1'b0, 12'd0);
        check("pend_0_9", next_interrupt, 12'd0);
        @(negedge clk);
        #7;
        rst = 1'b0;
        #1;
        check("async_reset", next_interrupt, NONE);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < N; i++) begin
            model_pend[i]  = 1'b0;
            model_delay[i] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [N-1:0] mask;
            logic         c;
            logic         d;
            logic [11:0]  num;
            @(negedge clk);
            c   = ($urandom_range(0, 3) == 0);
            d   = ($urandom_range(0, 2) == 0);
            num = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(24, 4095))
                                              : 12'($urandom_range(0, 27));
            mask = '0;
            for (int i = 0; i < N; i++) begin
                if (model_delay[i] == 0 && $urandom_range(0, 15) == 0) begin
                    mask[i]        = 1'b1;
                    model_delay[i] = 3;
                end
            end
            create  = c;
            dismiss = d;
            data_in = num;
            pulse(mask);
            @(posedge clk);
            for (int i = 0; i < N; i++) begin
                bit arrive;
                arrive = 1'b0;
                if (model_delay[i] > 0) begin
                    model_delay[i]--;
                    arrive = (model_delay[i] == 0);
                end
                if (d && num == 12'(i)) model_pend[i] = 1'b0;
                if (arrive || (c && num == 12'(i))) model_pend[i] = 1'b1;
            end
            #1;
            create  = 1'b0;
            dismiss = 1'b0;
            check($sformatf("random_cyc%0d", cyc), next_interrupt, model_next());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
